// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES key expansion, one 32-bit word per clock, with a registered round-key read port.
// Defining AES_KEY_ZEROIZE_EN adds a zeroize input that wipes the word store and returns to IDLE.
package aes_key_pkg;
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [79:0] RCON_TBL = 80'h36_1b_80_40_20_10_08_04_02_01;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 sits in bits [7:0], so rotating left by one byte moves the low byte to the top.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        return RCON_TBL[{n - 4'd1, 3'b000} +: 8];
    endfunction
endpackage

module aes_key_sched_ctrl
    import aes_key_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic [32*Nk-1:0]  key,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              sched_rdy,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk
);
    localparam int NW = 4 * (Nr + 1);
    localparam logic [5:0] NK6 = 6'(Nk);
    localparam logic [5:0] LAST = 6'(NW - 1);
    localparam logic [2:0] SUB_LAST = 3'(Nk - 1);
    localparam logic [3:0] NR4 = 4'(Nr);
    localparam bit BIG = Nk > 6;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t state_q, state_d;
    logic [5:0] i_q, i_d;
    logic [2:0] sub_q, sub_d;
    logic [3:0] rc_q, rc_d;
    logic [127:0] rk_q, rk_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];
    logic [31:0] prev, temp;
    logic [5:0] base;
    logic zero, accept;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif

    assign key_ready = state_q != EXPAND;
    assign sched_rdy = state_q == READY;
    assign accept = key_valid && key_ready && !zero;
    assign rk = rk_q;
    assign base = {rk_idx, 2'b00};
    assign prev = w_q[i_q - 6'd1];
    // sub_q tracks i mod Nk and rc_q tracks i / Nk, avoiding dividers.
    assign temp = (sub_q == 3'd0) ? sub_word(rot_word(prev)) ^ {24'h0, rcon(rc_q)}
                : (BIG && sub_q == 3'd4) ? sub_word(prev) : prev;

    always_comb begin
        state_d = state_q;
        i_d = i_q;
        sub_d = sub_q;
        rc_d = rc_q;
        w_d = w_q;
        rk_d = (sched_rdy && rk_idx <= NR4)
             ? {w_q[base + 6'd3], w_q[base + 6'd2], w_q[base + 6'd1], w_q[base]} : '0;
        if (zero) begin
            state_d = IDLE;
            rk_d = '0;
            for (int k = 0; k < NW; k++) w_d[k] = '0;
        end else if (accept) begin
            state_d = EXPAND;
            i_d = NK6;
            sub_d = 3'd0;
            rc_d = 4'd1;
            for (int k = 0; k < Nk; k++) w_d[k] = key[32*k +: 32];
        end else if (state_q == EXPAND) begin
            w_d[i_q] = w_q[i_q - NK6] ^ temp;
            i_d = i_q + 6'd1;
            sub_d = (sub_q == SUB_LAST) ? 3'd0 : sub_q + 3'd1;
            rc_d = (sub_q == SUB_LAST) ? rc_q + 4'd1 : rc_q;
            state_d = (i_q == LAST) ? READY : EXPAND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q <= '0;
            sub_q <= '0;
            rc_q <= '0;
            rk_q <= '0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            sub_q <= sub_d;
            rc_q <= rc_d;
            rk_q <= rk_d;
        end
    end

    // The word store has no reset; rst only freezes it for that cycle.
    always_ff @(posedge clk) begin
        if (!rst) w_q <= w_d;
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed FIPS-197 vectors against Nk=4 and Nk=8 instances of aes_key_sched_ctrl.
// Golden words are FIPS byte-stream order; the codebase packs byte 0 of the stream at bit 0.
module tb_aes_key_sched_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [127:0] key4 = '0;
    logic [255:0] key8 = '0;
    logic kv4 = 1'b0;
    logic kv8 = 1'b0;
    logic [3:0] idx4 = '0;
    logic [3:0] idx8 = '0;
    logic kr4, kr8, sr4, sr8;
    logic [127:0] rk4, rk8;
`ifdef AES_KEY_ZEROIZE_EN
    logic z4 = 1'b0;
    logic z8 = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int n, nr;

    typedef struct {
        logic         wide;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;
    vec_t vt [32];

    localparam logic [127:0] G4 [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f, 128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00, 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd, 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f, 128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };
    localparam logic [127:0] G8 [15] = '{
        128'h603deb10_15ca71be_2b73aef0_857d7781, 128'h1f352c07_3b6108d7_2d9810a3_0914dff4,
        128'h9ba35411_8e6925af_a51a8b5f_2067fcde, 128'ha8b09c1a_93d194cd_be49846e_b75d5b9a,
        128'hd59aecb8_5bf3c917_fee94248_de8ebe96, 128'hb5a9328a_2678a647_98312229_2f6c79b3,
        128'h812c81ad_dadf48ba_24360af2_fab8b464, 128'h98c5bfc9_bebd198e_268c3ba7_09e04214,
        128'h68007bac_b2df3316_96e939e4_6c518d80, 128'hc814e204_76a9fb8a_5025c02d_59c58239,
        128'hde136967_6ccc5a71_fa256395_9674ee15, 128'h5886ca5d_2e2f31d7_7e0af1fa_27cf73c3,
        128'h749c47ab_18501dda_e2757e4f_7401905a, 128'hcafaaae3_e4d59b34_9adf6ace_bd10190d,
        128'hfe4890d1_e6188d0b_046df344_706c631e
    };

    aes_key_sched_ctrl #(.Nk(4)) u4 (
        .clk(clk), .rst(rst),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(z4),
`endif
        .key(key4), .key_valid(kv4), .key_ready(kr4), .sched_rdy(sr4), .rk_idx(idx4), .rk(rk4)
    );

    aes_key_sched_ctrl #(.Nk(8)) u8 (
        .clk(clk), .rst(rst),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(z8),
`endif
        .key(key8), .key_valid(kv8), .key_ready(kr8), .sched_rdy(sr8), .rk_idx(idx8), .rk(rk8)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] brev128(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = x[127-8*b -: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rdy(input logic wide, output int cnt);
        cnt = 0;
        while (!(wide ? sr8 : sr4) && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int v = lo; v < hi; v++) begin
            if (vt[v].wide) idx8 = vt[v].idx;
            else idx4 = vt[v].idx;
            tick();
            check($sformatf("rk_%s_idx%0d", vt[v].wide ? "nk8" : "nk4", vt[v].idx),
                  {128'h0, vt[v].wide ? rk8 : rk4}, {128'h0, vt[v].exp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < 16; j++) begin
            vt[j].wide = 1'b0;
            vt[j].idx = 4'(j);
            if (j <= 10) vt[j].exp = brev128(G4[j]);
            else vt[j].exp = '0;
            vt[16+j].wide = 1'b1;
            vt[16+j].idx = 4'(j);
            if (j <= 14) vt[16+j].exp = brev128(G8[j]);
            else vt[16+j].exp = '0;
        end
        repeat (2) tick();
        check("rst_key_ready4", kr4, 1);
        check("rst_sched_rdy4", sr4, 0);
        check("rst_rk4", rk4, 0);
        check("rst_key_ready8", kr8, 1);
        check("rst_sched_rdy8", sr8, 0);
        check("rst_rk8", rk8, 0);
        rst = 1'b0;
        tick();
        // abandoned expansion: reset lands in cycle T+20
        key4 = {4{32'hdeadbeef}};
        kv4 = 1'b1;
        tick();
        kv4 = 1'b0;
        check("expand_key_ready4", kr4, 0);
        repeat (18) tick();
        idx4 = 4'd0;
        tick();
        check("partial_read_rk4", rk4, 0);
        check("partial_sched_rdy4", sr4, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sched_rdy4", sr4, 0);
        check("midrst_key_ready4", kr4, 1);
        check("midrst_rk4", rk4, 0);
        repeat (45) tick();
        check("abandoned_sched_rdy4", sr4, 0);
        // FIPS A.1 with key_valid held high and the key changing during EXPAND
        key4 = brev128(G4[0]);
        kv4 = 1'b1;
        tick();
        n = 0;
        nr = 0;
        while (!sr4 && n < 200) begin
            key4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (!kr4) nr++;
            tick();
            n++;
        end
        kv4 = 1'b0;
        check("latency_nk4", n, 40);
        check("key_ready_low_cycles", nr, 40);
        check("ready_key_ready4", kr4, 1);
        apply(0, 16);
        // reload from READY drops sched_rdy on the next cycle
        key4 = {4{32'h01234567}};
        kv4 = 1'b1;
        check("reload_pre_sched_rdy4", sr4, 1);
        tick();
        kv4 = 1'b0;
        check("reload_sched_rdy4", sr4, 0);
        check("reload_key_ready4", kr4, 0);
        idx4 = 4'd10;
        tick();
        check("reload_read_rk4", rk4, 0);
        wait_rdy(1'b0, n);
        check("reload_latency_nk4", n, 39);
        // FIPS A.3
        key8 = {brev128(G8[1]), brev128(G8[0])};
        kv8 = 1'b1;
        tick();
        kv8 = 1'b0;
        wait_rdy(1'b1, n);
        check("latency_nk8", n, 52);
        apply(16, 32);
`ifdef AES_KEY_ZEROIZE_EN
        begin
            logic [31:0] acc;
            z4 = 1'b1;
            kv4 = 1'b1;
            key4 = brev128(G4[0]);
            tick();
            z4 = 1'b0;
            kv4 = 1'b0;
            check("zeroize_key_ready4", kr4, 1);
            check("zeroize_sched_rdy4", sr4, 0);
            check("zeroize_rk4", rk4, 0);
            acc = '0;
            for (int k = 0; k < 44; k++) acc |= u4.w_q[k];
            check("zeroize_words4", acc, 0);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
